// File: rtl/alu_op_sequencer_if.sv
// Command channel between an issuer and alu_op_sequencer: one three-address
// ALU command (op, rs1, rs2, rd) per valid/ready handshake.
`timescale 1ns/1ps
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [4:0] cmd_rs1;
  logic [4:0] cmd_rs2;
  logic [4:0] cmd_rd;

  modport master (output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, output cmd_ready);
endinterface

// File: rtl/alu_op_sequencer.sv
// Operand fetch / write-back sequencer around an external combinational ALU.
// Optional macro ALU_R0_ZERO_EN makes register 0 hardwired to zero.
`timescale 1ns/1ps
module alu_op_sequencer (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_op_sequencer_if.slave       cmd,
  input  logic                    ld_en,
  input  logic [4:0]              ld_addr,
  input  logic [31:0]             ld_data,
  output logic [2:0]              alu_op,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  input  logic [31:0]             alu_f,
  input  logic                    alu_of,
  input  logic                    alu_zf,
  output logic                    done,
  output logic [31:0]             result,
  output logic                    flag_of,
  output logic                    flag_zf,
  input  logic [4:0]              dbg_addr,
  output logic [31:0]             dbg_data
);

`ifdef ALU_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [4:0]         rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [31:0][31:0]  regs_q, regs_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [31:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [31:0]        res_q, res_d;
  logic               of_q, of_d, zf_q, zf_d;
  logic [31:0]        result_q, result_d;
  logic               flag_of_q, flag_of_d, flag_zf_q, flag_zf_d;
  logic               done_q, done_d;

  function automatic logic [31:0] rf_read(input logic [31:0][31:0] rf, input logic [4:0] a);
    return (R0_ZERO && a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  function automatic logic rf_wr_ok(input logic [4:0] a);
    return !(R0_ZERO && a == 5'd0);
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    regs_d    = regs_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    res_d     = res_q;
    of_d      = of_q;
    zf_d      = zf_q;
    result_d  = result_q;
    flag_of_d = flag_of_q;
    flag_zf_d = flag_zf_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Direct loads land at the accept edge, so READ already sees them.
        if (ld_en && rf_wr_ok(ld_addr)) regs_d[ld_addr] = ld_data;
        if (cmd.cmd_valid) begin
          op_d    = cmd.cmd_op;
          rs1_d   = cmd.cmd_rs1;
          rs2_d   = cmd.cmd_rs2;
          rd_d    = cmd.cmd_rd;
          state_d = S_READ;
        end
      end
      S_READ: begin
        alu_op_d = op_q;
        alu_a_d  = rf_read(regs_q, rs1_q);
        alu_b_d  = rf_read(regs_q, rs2_q);
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_f;
        of_d    = alu_of;
        zf_d    = alu_zf;
        state_d = S_WB;
      end
      S_WB: begin
        if (rf_wr_ok(rd_q)) regs_d[rd_q] = res_q;
        result_d  = res_q;
        flag_of_d = of_q;
        flag_zf_d = zf_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      regs_q    <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      res_q     <= '0;
      of_q      <= 1'b0;
      zf_q      <= 1'b0;
      result_q  <= '0;
      flag_of_q <= 1'b0;
      flag_zf_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      regs_q    <= regs_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      res_q     <= res_d;
      of_q      <= of_d;
      zf_q      <= zf_d;
      result_q  <= result_d;
      flag_of_q <= flag_of_d;
      flag_zf_q <= flag_zf_d;
      done_q    <= done_d;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign alu_op        = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign done          = done_q;
  assign result        = result_q;
  assign flag_of       = flag_of_q;
  assign flag_zf       = flag_zf_q;
  assign dbg_data      = rf_read(regs_q, dbg_addr);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + randomized bench for alu_op_sequencer with an ALU model on the
// datapath side and a register-file reference model (honours ALU_R0_ZERO_EN).
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_f;
  logic        alu_of, alu_zf;
  logic        done;
  logic [31:0] result;
  logic        flag_of, flag_zf;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int vecs = 0;
  int errs = 0;
  logic [31:0] mrf [32];

  alu_op_sequencer_if cmd_if ();

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_of(alu_of), .alu_zf(alu_zf),
    .done(done), .result(result), .flag_of(flag_of), .flag_zf(flag_zf),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fn_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a ^ b;
      3'b011: return ~(a | b);
      3'b100: return a + b;
      3'b101: return a - b;
      3'b110: return {31'd0, $signed(a) < $signed(b)};
      default: return b << a[4:0];
    endcase
  endfunction

  function automatic logic fn_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    if (op == 3'b100) begin s = a + b; return (a[31] == b[31]) && (s[31] != a[31]); end
    if (op == 3'b101) begin s = a - b; return (a[31] != b[31]) && (s[31] != a[31]); end
    return 1'b0;
  endfunction

  // The external combinational ALU
  always_comb begin
    alu_f  = fn_f(alu_op, alu_a, alu_b);
    alu_of = fn_of(alu_op, alu_a, alu_b);
    alu_zf = (alu_f == 32'd0);
  end

  function automatic logic [31:0] mread(input logic [4:0] a);
`ifdef ALU_R0_ZERO_EN
    if (a == 5'd0) return 32'd0;
`endif
    return mrf[a];
  endfunction

  task automatic mwrite(input logic [4:0] a, input logic [31:0] v);
`ifdef ALU_R0_ZERO_EN
    if (a == 5'd0) return;
`endif
    mrf[a] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic dbg_chk(input string tag, input logic [4:0] a, input logic [31:0] exp_v);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp_v);
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mwrite(a, v);
  endtask

  // One full command with per-cycle checks; optional load in the accept
  // cycle and an ignored load held through READ/EXEC/WB.
  task automatic issue(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input bit ld_acc, input logic [4:0] la,
                       input logic [31:0] lv, input bit busy_ld);
    logic [31:0] ea, eb, ef;
    logic        eof;
    logic [4:0]  ba;
    @(negedge clk);
    chk("ready_idle", {31'd0, cmd_if.cmd_ready}, 32'd1);
    cmd_if.cmd_op = op; cmd_if.cmd_rs1 = s1; cmd_if.cmd_rs2 = s2; cmd_if.cmd_rd = d;
    cmd_if.cmd_valid = 1'b1;
    ld_en = ld_acc; ld_addr = la; ld_data = lv;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    if (ld_acc) mwrite(la, lv);
    ba = 5'($urandom);
    ld_en = busy_ld; ld_addr = ba; ld_data = $urandom;
    ea = mread(s1); eb = mread(s2);
    ef = fn_f(op, ea, eb); eof = fn_of(op, ea, eb);
    @(negedge clk);
    chk("ready_read", {31'd0, cmd_if.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("ready_exec", {31'd0, cmd_if.cmd_ready}, 32'd0);
    chk("alu_op", {29'd0, alu_op}, {29'd0, op});
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    @(negedge clk);
    chk("ready_wb", {31'd0, cmd_if.cmd_ready}, 32'd0);
    chk("done_wb", {31'd0, done}, 32'd0);
    @(negedge clk);
    ld_en = 1'b0;
    chk("done", {31'd0, done}, 32'd1);
    chk("ready_done", {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("result", result, ef);
    chk("flag_of", {31'd0, flag_of}, {31'd0, eof});
    chk("flag_zf", {31'd0, flag_zf}, {31'd0, ef == 32'd0});
    mwrite(d, ef);
    dbg_chk("rf_rd", d, mread(d));
    if (busy_ld) dbg_chk("busy_ld_ignored", ba, mread(ba));
  endtask

  initial begin
    int acc_cyc [$];
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = '0;
    cmd_if.cmd_rs1 = '0; cmd_if.cmd_rs2 = '0; cmd_if.cmd_rd = '0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'd0, flag_of, flag_zf}, 32'd0);
    for (int i = 0; i < 32; i++) dbg_chk("rst_rf", 5'(i), 32'd0);

    // ADD r1+r2 -> r3
    load(5'd1, 32'h0000_0005);
    load(5'd2, 32'h0000_0003);
    issue(3'b100, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0);
    dbg_chk("add_r3", 5'd3, 32'd8);
    chk("add_zf", {31'd0, flag_zf}, 32'd0);

    // Signed overflow
    load(5'd4, 32'h7FFF_FFFF);
    load(5'd5, 32'h0000_0001);
    issue(3'b100, 5'd4, 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0);
    dbg_chk("ovf_r6", 5'd6, 32'h8000_0000);
    chk("ovf_of", {31'd0, flag_of}, 32'd1);

    // SUB r7-r7 -> r7, loaded in the accept cycle
    issue(3'b101, 5'd7, 5'd7, 5'd7, 1'b1, 5'd7, 32'h1234_5678, 1'b1);
    dbg_chk("sub_r7", 5'd7, 32'd0);
    chk("sub_zf", {31'd0, flag_zf}, 32'd1);

    // Back-to-back with cmd_valid held; loads attempted only while busy
    load(5'd9, $urandom);
    @(negedge clk);
    cmd_if.cmd_op = 3'b100; cmd_if.cmd_rs1 = 5'd9; cmd_if.cmd_rs2 = 5'd1; cmd_if.cmd_rd = 5'd9;
    for (int c = 0; c < 17; c++) begin
      cmd_if.cmd_valid = (c < 13);
      ld_en = !cmd_if.cmd_ready; ld_addr = 5'd1; ld_data = 32'hDEAD_BEEF;
      if (cmd_if.cmd_ready && cmd_if.cmd_valid) acc_cyc.push_back(c);
      if (c < 16) @(negedge clk);
    end
    ld_en = 1'b0; cmd_if.cmd_valid = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 32'd4);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("b2b_gap", acc_cyc[k] - acc_cyc[k-1], 32'd4);
    for (int k = 0; k < 4; k++) mwrite(5'd9, mread(5'd9) + mread(5'd1));
    dbg_chk("b2b_r9", 5'd9, mread(5'd9));
    dbg_chk("b2b_r1_kept", 5'd1, 32'd5);
    chk("b2b_result", result, mread(5'd9));

    // Reset during EXEC aborts the command
    load(5'd8, 32'h0000_00AA);
    dbg_chk("pre_r8", 5'd8, 32'h0000_00AA);
    @(negedge clk);
    cmd_if.cmd_op = 3'b100; cmd_if.cmd_rs1 = 5'd1; cmd_if.cmd_rs2 = 5'd2; cmd_if.cmd_rd = 5'd8;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    chk("abort_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("abort_result", result, 32'd0);
    dbg_chk("abort_r8", 5'd8, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end

    // Register 0 behaviour
    load(5'd0, 32'hFFFF_FFFF);
    issue(3'b001, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
`ifdef ALU_R0_ZERO_EN
    dbg_chk("r0_zero", 5'd0, 32'd0);
    chk("r0_result", result, 32'd0);
    chk("r0_zf", {31'd0, flag_zf}, 32'd1);
`else
    dbg_chk("r0_plain", 5'd0, 32'hFFFF_FFFF);
    chk("r0_result", result, 32'hFFFF_FFFF);
`endif

    // Randomized commands against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [4:0] s1, s2, d, la;
      s1 = 5'($urandom); s2 = 5'($urandom); d = 5'($urandom);
      if ($urandom_range(0, 1) == 1) load(5'($urandom), $urandom);
      la = ($urandom_range(0, 1) == 1) ? s1 : 5'($urandom);
      issue(3'($urandom), s1, s2, d, 1'($urandom), la, $urandom, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
